// File: rtl/mna_irq_agg.sv
// Interrupt aggregator for the MNA block: synchronises nine level sources, latches rising
// edges into W1C pending bits, masks them with an enable register and drives one registered
// interrupt. The register file sits on a zero-wait-state APB slave.
// Defining MNA_IRQ_AGG_CNT_EN adds a saturating event counter at offset 0x010.
module mna_irq_agg #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        i_clk_peri2mna,
  input  logic        i_rstn_peri2mna,
  input  logic [8:0]  i_irq_src,
  input  logic        i_psel,
  input  logic        i_penable,
  input  logic        i_pwrite,
  input  logic [11:0] i_paddr,
  input  logic [31:0] i_pwdata,
  output logic        o_pready,
  output logic [31:0] o_prdata,
  output logic        o_pslverr,
  output logic        o_irq
);

  localparam logic [2:0] REG_RAW  = 3'd0;
  localparam logic [2:0] REG_PEND = 3'd1;
  localparam logic [2:0] REG_EN   = 3'd2;
  localparam logic [2:0] REG_STAT = 3'd3;
  localparam logic [2:0] REG_CNT  = 3'd4;

  logic [SYNC_STAGES-1:0][8:0] sync_q;
  logic [8:0]  sync_last;
  logic [8:0]  sync_d;
  logic [8:0]  evt;
  logic [8:0]  pend_q;
  logic [8:0]  en_q;
  logic [8:0]  pend_clr;
  logic        irq_q;
  logic        addr_ok;
  logic [2:0]  reg_sel;
  logic        wr_en;
  logic [15:0] cnt_rd;
  logic [31:0] rdata;
  logic        unused_pwdata;

  // NOTE: every flop, including the synchroniser chain, gets the async reset so a source held
  // high across reset release is seen as exactly one fresh rising edge.
  always_ff @(posedge i_clk_peri2mna or negedge i_rstn_peri2mna) begin
    if (!i_rstn_peri2mna) begin
      sync_q <= '0;
      sync_d <= '0;
    end else begin
      // NOTE: non-blocking assignments keep each stage reading last cycle's value.
      sync_q <= {sync_q[SYNC_STAGES-2:0], i_irq_src};
      sync_d <= sync_last;
    end
  end

  assign sync_last = sync_q[SYNC_STAGES-1];
  assign evt       = sync_last & ~sync_d;

  // Only word offsets 0x000..0x010 decode; anything else is a slave error.
  assign addr_ok = (i_paddr[1:0] == 2'b00) && (i_paddr[11:5] == 7'd0) && (i_paddr[4:2] <= REG_CNT);
  assign reg_sel = i_paddr[4:2];
  assign wr_en   = i_psel && i_penable && i_pwrite && addr_ok;

  assign pend_clr = (wr_en && reg_sel == REG_PEND) ? i_pwdata[8:0] : 9'd0;

  always_ff @(posedge i_clk_peri2mna or negedge i_rstn_peri2mna) begin
    if (!i_rstn_peri2mna) begin
      pend_q <= '0;
      en_q   <= '0;
      irq_q  <= 1'b0;
    end else begin
      // A new edge beats a simultaneous W1C so no event is ever lost.
      pend_q <= (pend_q & ~pend_clr) | evt;
      if (wr_en && reg_sel == REG_EN) en_q <= i_pwdata[8:0];
      irq_q  <= |(pend_q & en_q);
    end
  end

`ifdef MNA_IRQ_AGG_CNT_EN
  logic [15:0] cnt_q;
  logic [16:0] cnt_sum;

  function automatic logic [3:0] popcount9(input logic [8:0] v);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 9; i++) n = n + {3'd0, v[i]};
    return n;
  endfunction

  assign cnt_sum = {1'b0, cnt_q} + {13'd0, popcount9(evt)};

  always_ff @(posedge i_clk_peri2mna or negedge i_rstn_peri2mna) begin
    if (!i_rstn_peri2mna) begin
      cnt_q <= '0;
    end else if (wr_en && reg_sel == REG_CNT) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
    end
  end

  assign cnt_rd = cnt_q;
`else
  assign cnt_rd = 16'd0;
`endif

  // NOTE: the default assignment first keeps this combinational mux free of latches.
  always_comb begin
    rdata = 32'd0;
    case (reg_sel)
      REG_RAW:  rdata = {23'd0, sync_last};
      REG_PEND: rdata = {23'd0, pend_q};
      REG_EN:   rdata = {23'd0, en_q};
      REG_STAT: rdata = {23'd0, pend_q & en_q};
      REG_CNT:  rdata = {16'd0, cnt_rd};
      default:  rdata = 32'd0;
    endcase
  end

  assign o_pready  = 1'b1;
  assign o_prdata  = (i_psel && !i_pwrite && addr_ok) ? rdata : 32'd0;
  assign o_pslverr = i_psel && i_penable && !addr_ok;
  assign o_irq     = irq_q;

  assign unused_pwdata = ^i_pwdata[31:9];

endmodule

// File: tb/tb_mna_irq_agg.sv
// Directed bench for mna_irq_agg: APB responses are checked through a scoreboard queue by a
// monitor on the falling edge; o_irq timing is checked inline against hand-derived cycles.
module tb_mna_irq_agg;

  localparam logic [11:0] A_RAW  = 12'h000;
  localparam logic [11:0] A_PEND = 12'h004;
  localparam logic [11:0] A_EN   = 12'h008;
  localparam logic [11:0] A_STAT = 12'h00C;
  localparam logic [11:0] A_CNT  = 12'h010;

  typedef struct {
    logic [31:0] data;
    logic        err;
    string       name;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [8:0]  irq_src;
  logic        psel, penable, pwrite;
  logic [11:0] paddr;
  logic [31:0] pwdata;
  logic        pready;
  logic [31:0] prdata;
  logic        pslverr;
  logic        irq;

  int checks = 0;
  int errors = 0;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  mna_irq_agg #(.SYNC_STAGES(2)) dut (
    .i_clk_peri2mna  (clk),
    .i_rstn_peri2mna (rst_n),
    .i_irq_src       (irq_src),
    .i_psel          (psel),
    .i_penable       (penable),
    .i_pwrite        (pwrite),
    .i_paddr         (paddr),
    .i_pwdata        (pwdata),
    .o_pready        (pready),
    .o_prdata        (prdata),
    .o_pslverr       (pslverr),
    .o_irq           (irq)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) tick();
  endtask

  task automatic apb_write(input logic [11:0] a, input logic [31:0] d, input logic err,
                           input string nm);
    psel = 1'b1; pwrite = 1'b1; penable = 1'b0; paddr = a; pwdata = d;
    tick();
    penable = 1'b1;
    sb_q.push_back('{data: 32'd0, err: err, name: nm});
    tick();
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_read(input logic [11:0] a, input logic [31:0] d, input logic err,
                          input string nm);
    psel = 1'b1; pwrite = 1'b0; penable = 1'b0; paddr = a;
    tick();
    penable = 1'b1;
    sb_q.push_back('{data: d, err: err, name: nm});
    tick();
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic pulse(input logic [8:0] v);
    irq_src = v;
    tick();
    irq_src = 9'd0;
    wait_cycles(4);
  endtask

  // Monitor: every access phase outside reset must match the oldest queued expectation.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n && psel && penable) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_resp: got prdata 0x%0h pslverr %0b with nothing queued",
                 prdata, pslverr);
      end else begin
        e = sb_q.pop_front();
        check({e.name, "_prdata"}, prdata, e.data);
        check({e.name, "_pslverr"}, {31'd0, pslverr}, {31'd0, e.err});
        check({e.name, "_pready"}, {31'd0, pready}, 32'd1);
      end
    end
  end

  initial begin
    rst_n = 1'b0; irq_src = '0; psel = 0; penable = 0; pwrite = 0; paddr = '0; pwdata = '0;
    #1;
    check("rst_irq", {31'd0, irq}, 32'd0);
    check("rst_pready", {31'd0, pready}, 32'd1);
    check("rst_prdata", prdata, 32'd0);
    check("rst_pslverr", {31'd0, pslverr}, 32'd0);
    #22 rst_n = 1'b1;
    tick();

    apb_read(A_PEND, 32'h000, 1'b0, "rst_pend");
    apb_read(A_EN,   32'h000, 1'b0, "rst_en");
    apb_read(A_RAW,  32'h000, 1'b0, "rst_raw");

    // Single-cycle pulse on done_irdma: PEND at N+2, o_irq at N+3.
    apb_write(A_EN, 32'h1FF, 1'b0, "en_all");
    irq_src = 9'h004;
    tick();
    irq_src = 9'h000;
    tick();
    check("pulse_irq_n1", {31'd0, irq}, 32'd0);
    tick();
    check("pulse_irq_n2", {31'd0, irq}, 32'd0);
    tick();
    check("pulse_irq_n3", {31'd0, irq}, 32'd1);
    apb_read(A_PEND, 32'h004, 1'b0, "pulse_pend");
    apb_read(A_STAT, 32'h004, 1'b0, "pulse_stat");
    apb_write(A_PEND, 32'h004, 1'b0, "pulse_w1c");
    check("w1c_irq_same", {31'd0, irq}, 32'd1);
    tick();
    check("w1c_irq_next", {31'd0, irq}, 32'd0);
    apb_read(A_PEND, 32'h000, 1'b0, "w1c_pend");

    // Masked event is retained and fires once enabled.
    apb_write(A_EN, 32'h000, 1'b0, "en_none");
    irq_src = 9'h080;
    wait_cycles(4);
    apb_read(A_RAW,  32'h080, 1'b0, "mask_raw");
    apb_read(A_PEND, 32'h080, 1'b0, "mask_pend");
    apb_read(A_STAT, 32'h000, 1'b0, "mask_stat");
    check("mask_irq", {31'd0, irq}, 32'd0);
    apb_write(A_EN, 32'h080, 1'b0, "en_b7");
    check("unmask_irq_same", {31'd0, irq}, 32'd0);
    tick();
    check("unmask_irq_next", {31'd0, irq}, 32'd1);
    apb_write(A_PEND, 32'h080, 1'b0, "clr_b7");
    tick();
    check("clr_b7_irq", {31'd0, irq}, 32'd0);
    irq_src = 9'h000;
    wait_cycles(3);

    // Event on bit0 coincident with W1C of bit0: set wins.
    pulse(9'h001);
    apb_read(A_PEND, 32'h001, 1'b0, "b0_pend");
    irq_src = 9'h001;
    tick();
    apb_write(A_PEND, 32'h001, 1'b0, "b0_w1c_race");
    apb_read(A_PEND, 32'h001, 1'b0, "b0_set_wins");
    apb_write(A_PEND, 32'h001, 1'b0, "b0_w1c");
    apb_read(A_PEND, 32'h000, 1'b0, "b0_cleared");
    irq_src = 9'h000;
    wait_cycles(3);

    // Address errors and read-only writes.
    apb_read(12'h014, 32'h0, 1'b1, "rd_oob");
    apb_read(12'h00A, 32'h0, 1'b1, "rd_misal");
    apb_write(12'h002, 32'h1FF, 1'b1, "wr_misal2");
    apb_write(12'h00A, 32'h000, 1'b1, "wr_misalA");
    apb_write(12'h808, 32'h000, 1'b1, "wr_hi_alias");
    apb_write(A_RAW, 32'h1FF, 1'b0, "wr_raw");
    apb_write(A_STAT, 32'h1FF, 1'b0, "wr_stat");
    apb_read(A_EN,   32'h080, 1'b0, "en_kept");
    apb_read(A_PEND, 32'h000, 1'b0, "pend_kept");
    apb_read(A_RAW,  32'h000, 1'b0, "raw_kept");

`ifdef MNA_IRQ_AGG_CNT_EN
    apb_write(A_CNT, 32'h0, 1'b0, "cnt_clr");
    pulse(9'h007);
    apb_read(A_CNT, 32'd3, 1'b0, "cnt_three");
    apb_write(A_CNT, 32'h0, 1'b0, "cnt_clr2");
    for (int i = 0; i < 7281; i++) begin
      irq_src = 9'h1FF;
      tick();
      irq_src = 9'h000;
      tick();
    end
    wait_cycles(4);
    pulse(9'h01F);
    apb_read(A_CNT, 32'hFFFE, 1'b0, "cnt_fffe");
    pulse(9'h003);
    apb_read(A_CNT, 32'hFFFF, 1'b0, "cnt_sat");
    pulse(9'h007);
    apb_read(A_CNT, 32'hFFFF, 1'b0, "cnt_sat_hold");
    apb_write(A_CNT, 32'h0, 1'b0, "cnt_clr3");
    apb_read(A_CNT, 32'h0, 1'b0, "cnt_zero");
`else
    pulse(9'h007);
    apb_read(A_CNT, 32'h0, 1'b0, "cnt_absent");
    apb_write(A_CNT, 32'hFFFF, 1'b0, "cnt_wr_absent");
    apb_read(A_CNT, 32'h0, 1'b0, "cnt_absent2");
`endif
    apb_write(A_PEND, 32'h1FF, 1'b0, "pend_clr_all");
    apb_read(A_PEND, 32'h000, 1'b0, "pend_all_clr");

    // Sources held high across reset produce exactly one event each.
    apb_write(A_EN, 32'h1FF, 1'b0, "en_all2");
    irq_src = 9'h1FF;
    wait_cycles(5);
    check("pre_rst_irq", {31'd0, irq}, 32'd1);
    #2 rst_n = 1'b0;
    #1 check("async_rst_irq", {31'd0, irq}, 32'd0);
    wait_cycles(2);
    #2 rst_n = 1'b1;
    wait_cycles(5);
    apb_read(A_PEND, 32'h1FF, 1'b0, "hold_pend");
    apb_read(A_EN,   32'h000, 1'b0, "hold_en_rst");
    apb_write(A_PEND, 32'h1FF, 1'b0, "hold_w1c");
    wait_cycles(4);
    apb_read(A_PEND, 32'h000, 1'b0, "hold_once");
    irq_src = 9'h000;
    wait_cycles(3);

    // Reset in the access phase of an EN write discards it.
    psel = 1'b1; pwrite = 1'b1; penable = 1'b0; paddr = A_EN; pwdata = 32'h1FF;
    tick();
    penable = 1'b1;
    #1 rst_n = 1'b0;
    tick();
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    #2 rst_n = 1'b1;
    tick();
    apb_read(A_EN, 32'h000, 1'b0, "rst_mid_en");
    check("rst_mid_irq", {31'd0, irq}, 32'd0);

    wait_cycles(2);
    check("sb_drained", sb_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mna_irq_agg.md
MNA_IRQ_AGG -- requirements
Module: mna_irq_agg

Interface
REQ-001 Parameter SYNC_STAGES, default 2, number of synchronizer flops per interrupt source (legal 2..4).
REQ-002 i_clk_peri2mna  in  1  sole clock, rising-edge.
REQ-003 i_rstn_peri2mna  in  1  asynchronous active-low reset.
REQ-004 i_irq_src  in  9  level interrupts from MNA; bit0 irq_mna, 1 err_irdma, 2 done_irdma, 3 err_prdma, 4 done_prdma, 5 err_wrdma, 6 done_wrdma, 7 err_owdma, 8 done_owdma.
REQ-005 i_psel, i_penable, i_pwrite  in  1 each  APB control.
REQ-006 i_paddr  in  12  APB byte address; i_pwdata  in  32  write data.
REQ-007 o_pready  out  1; o_prdata  out  32; o_pslverr  out  1  APB response.
REQ-008 o_irq  out  1  registered combined interrupt to the system interrupt controller.

Function
REQ-009 Each i_irq_src bit SHALL pass through SYNC_STAGES flops, then one delay flop (sync_d); event = sync_last & ~sync_d (rising edge).
REQ-010 PEND[8:0] bit SHALL set on the cycle after its event; remains set until cleared by software.
REQ-011 Register map: 0x000 RAW (RO, sync_last), 0x004 PEND (W1C), 0x008 EN (RW, bits 8:0), 0x00C STAT (RO, PEND & EN), 0x010 CNT (see Configuration); unused bits read 0.
REQ-012 Event and W1C on same bit same cycle: set wins, bit stays 1.
REQ-013 o_irq SHALL be registered |(PEND & EN); asserts one cycle after PEND/EN change; source high sampled at edge N -> PEND at edge N+SYNC_STAGES, o_irq at edge N+SYNC_STAGES+1.
REQ-014 APB zero-wait: o_pready constantly 1; write commits at edge ending access phase (psel & penable & pwrite).
REQ-015 o_prdata SHALL be combinational from registers during psel & ~pwrite, else 0.
REQ-016 Address outside map or not word-aligned: o_pslverr=1 in access phase, write ignored, o_prdata=0.
REQ-017 Writes to RO registers: ignored, o_pslverr=0.
REQ-018 Clearing EN bit masks only; PEND retains events arriving while masked.

Reset
REQ-019 On i_rstn_peri2mna low, all sync flops, sync_d, PEND, EN, CNT, o_irq SHALL clear to 0 immediately.
REQ-020 o_pready reset value 1; o_prdata 0; o_pslverr 0.
REQ-021 A source held high across reset release SHALL produce exactly one event after release.
REQ-022 Reset mid APB transfer: transfer discarded, no register updated.

Configuration
REQ-023 Macro MNA_IRQ_AGG_CNT_EN defined: CNT[15:0] at 0x010 increments by popcount of events per cycle, saturates at 0xFFFF; any write clears to 0; write and events same cycle: clear wins (result 0).
REQ-024 Macro undefined: no counter logic; 0x010 remains a legal address, reads 0, writes ignored, o_pslverr=0.

Verification
REQ-025 EN=0x1FF, pulse i_irq_src[2] high 1 cycle at edge N -> PEND=0x004 at N+2, o_irq=1 at N+3; write 0x004 to PEND -> o_irq=0 one cycle later.
REQ-026 EN=0x000, raise i_irq_src[7] -> PEND=0x080, STAT=0x000, o_irq stays 0; write EN=0x080 -> o_irq=1 next cycle.
REQ-027 Rising edge of bit0 on same cycle as W1C of 0x001 -> PEND bit0 remains 1.
REQ-028 Read 0x014 and write 0x002 -> o_pslverr=1, o_prdata=0, no register changes.
REQ-029 With MNA_IRQ_AGG_CNT_EN: three sources rise together -> CNT=3; preload to 0xFFFE via events then two more -> CNT=0xFFFF; without macro CNT reads 0.
REQ-030 Hold i_irq_src=0x1FF through reset, release -> PEND=0x1FF exactly once; assert reset during APB write to EN -> EN=0 after release.
